// File: rtl/wash_sequencer.sv
// Washing-machine cycle controller: IDLE -> FILL -> WASH -> DRAIN -> SPIN -> DONE, with
// a per-phase two-digit BCD countdown clocked by the 1 Hz tick and a fill timeout to ERROR.
module wash_sequencer #(
  parameter int FILL_TIMEOUT_SEC = 20,
  parameter int WASH_SEC         = 30,
  parameter int DRAIN_SEC        = 10,
  parameter int SPIN_SEC         = 15
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       water_full,
  output logic [2:0] state,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       valve_in,
  output logic       motor,
  output logic       valve_out,
  output logic       spin,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_SPIN  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  function automatic logic [7:0] to_bcd(input int p);
    to_bcd = {4'(p / 10), 4'(p % 10)};
  endfunction

  localparam logic [7:0] FILL_BCD  = to_bcd(FILL_TIMEOUT_SEC);
  localparam logic [7:0] WASH_BCD  = to_bcd(WASH_SEC);
  localparam logic [7:0] DRAIN_BCD = to_bcd(DRAIN_SEC);
  localparam logic [7:0] SPIN_BCD  = to_bcd(SPIN_SEC);

  state_t     state_q;
  logic [3:0] tens_q, ones_q;
  logic [3:0] tens_d, ones_d;
  logic       run, at_one;

  assign run    = tick & ~pause;
  assign at_one = (tens_q == 4'd0) && (ones_q == 4'd1);

  // BCD borrow; 00 holds so the digits never leave 0..9.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (ones_q != 4'd0) begin
      ones_d = ones_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      tens_d = tens_q - 4'd1;
      ones_d = 4'd9;
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_q <= S_IDLE;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          state_q          <= S_FILL;
          {tens_q, ones_q} <= FILL_BCD;
        end
        // Drum full takes priority over a coincident timeout; pause holds the phase.
        S_FILL: if (water_full && !pause) begin
          state_q          <= S_WASH;
          {tens_q, ones_q} <= WASH_BCD;
        end else if (run) begin
          if (at_one) begin
            state_q          <= S_ERROR;
            {tens_q, ones_q} <= 8'h00;
          end else begin
            {tens_q, ones_q} <= {tens_d, ones_d};
          end
        end
        S_WASH: if (run) begin
          if (at_one) begin
            state_q          <= S_DRAIN;
            {tens_q, ones_q} <= DRAIN_BCD;
          end else begin
            {tens_q, ones_q} <= {tens_d, ones_d};
          end
        end
        S_DRAIN: if (run) begin
          if (at_one) begin
            state_q          <= S_SPIN;
            {tens_q, ones_q} <= SPIN_BCD;
          end else begin
            {tens_q, ones_q} <= {tens_d, ones_d};
          end
        end
        S_SPIN: if (run) begin
          if (at_one) begin
            state_q          <= S_DONE;
            {tens_q, ones_q} <= 8'h00;
          end else begin
            {tens_q, ones_q} <= {tens_d, ones_d};
          end
        end
        S_ERROR: if (start) begin
          state_q          <= S_IDLE;
          {tens_q, ones_q} <= 8'h00;
        end
        default: begin
          state_q          <= S_IDLE;
          {tens_q, ones_q} <= 8'h00;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign sec_tens  = tens_q;
  assign sec_ones  = ones_q;
  assign valve_in  = (state_q == S_FILL) & ~pause;
  assign motor     = (state_q == S_WASH) & ~pause;
  assign valve_out = ((state_q == S_DRAIN) | (state_q == S_SPIN)) & ~pause;
  assign spin      = (state_q == S_SPIN) & ~pause;
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERROR);
endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: integer-seconds phase model compared every cycle,
// plus directed literal checks that pin the model.
module tb_wash_sequencer;
  localparam int FILL_T = 20, WASH_T = 12, DRAIN_T = 10, SPIN_T = 15;

  logic       CP = 1'b0, nCR = 1'b0;
  logic       tick = 1'b0, start = 1'b0, pause = 1'b0, water_full = 1'b0;
  logic [2:0] state;
  logic [3:0] sec_tens, sec_ones;
  logic       valve_in, motor, valve_out, spin, done, err;

  int checks = 0, errors = 0;
  bit cmp_en = 1'b0;

  wash_sequencer #(.FILL_TIMEOUT_SEC(FILL_T), .WASH_SEC(WASH_T),
                   .DRAIN_SEC(DRAIN_T), .SPIN_SEC(SPIN_T)) dut (
    .CP(CP), .nCR(nCR), .tick(tick), .start(start), .pause(pause),
    .water_full(water_full), .state(state), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .valve_in(valve_in), .motor(motor),
    .valve_out(valve_out), .spin(spin), .done(done), .err(err));

  always #5 CP = ~CP;

  // Model: phase number plus seconds remaining as a plain integer.
  int m_ph = 0, m_rem = 0;
  function automatic int dur(input int ph);
    case (ph)
      1: dur = FILL_T;
      2: dur = WASH_T;
      3: dur = DRAIN_T;
      4: dur = SPIN_T;
      default: dur = 0;
    endcase
  endfunction

  always @(posedge CP or negedge nCR) begin
    int ph, rem;
    if (!nCR) begin
      m_ph  <= 0;
      m_rem <= 0;
    end else begin
      ph = m_ph; rem = m_rem;
      if ((ph == 0 || ph == 5) && start) begin
        ph = 1; rem = FILL_T;
      end else if (ph == 6 && start) begin
        ph = 0; rem = 0;
      end else if (ph == 1 && water_full && !pause) begin
        ph = 2; rem = WASH_T;
      end else if (ph >= 1 && ph <= 4 && tick && !pause) begin
        if (rem == 1) begin
          ph  = (ph == 1) ? 6 : ph + 1;
          rem = dur(ph);
        end else begin
          rem = rem - 1;
        end
      end
      m_ph  <= ph;
      m_rem <= rem;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CP) begin
    if (cmp_en) begin
      bit act_on;
      act_on = (m_ph >= 1 && m_ph <= 4) && !pause;
      chk("m_state", int'(state), m_ph);
      chk("m_tens", int'(sec_tens), m_rem / 10);
      chk("m_ones", int'(sec_ones), m_rem % 10);
      chk("m_valve_in", int'(valve_in), int'(act_on && m_ph == 1));
      chk("m_motor", int'(motor), int'(act_on && m_ph == 2));
      chk("m_valve_out", int'(valve_out), int'(act_on && (m_ph == 3 || m_ph == 4)));
      chk("m_spin", int'(spin), int'(act_on && m_ph == 4));
      chk("m_done", int'(done), int'(m_ph == 5));
      chk("m_err", int'(err), int'(m_ph == 6));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CP);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1; cyc(1);
      tick = 1'b0; cyc(1);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1);
    start = 1'b0;
  endtask

  task automatic chk_dig(input string name, input int t, input int o);
    chk({name, "_tens"}, int'(sec_tens), t);
    chk({name, "_ones"}, int'(sec_ones), o);
  endtask

  initial begin
    cmp_en = 1'b1;
    #3;
    chk("rst_state", int'(state), 0);
    chk_dig("rst", 0, 0);
    chk("rst_done_err", int'({done, err}), 0);
    cyc(2);
    nCR = 1'b1;
    cyc(2);
    chk_dig("idle", 0, 0);

    pulse_start();
    chk("fill_state", int'(state), 1);
    chk_dig("fill", 2, 0);
    chk("fill_valve_in", int'(valve_in), 1);
    cyc(1);
    water_full = 1'b1; cyc(1);
    water_full = 1'b0;
    chk("wash_state", int'(state), 2);
    chk_dig("wash", 1, 2);
    chk("wash_motor", int'(motor), 1);
    chk("wash_valve_in", int'(valve_in), 0);

    ticks(2);
    chk_dig("wash2", 1, 0);
    ticks(1);
    chk_dig("borrow", 0, 9);

    pause = 1'b1;
    ticks(5);
    chk_dig("paused", 0, 9);
    chk("paused_motor", int'(motor), 0);
    chk("paused_state", int'(state), 2);
    pause = 1'b0; cyc(1);
    chk("resume_motor", int'(motor), 1);
    ticks(8);
    chk_dig("wash_last", 0, 1);
    ticks(1);
    chk("drain_state", int'(state), 3);
    chk_dig("drain", 1, 0);
    chk("drain_valve_out", int'(valve_out), 1);

    ticks(DRAIN_T);
    chk("spin_state", int'(state), 4);
    chk_dig("spin", 1, 5);
    chk("spin_en", int'({spin, valve_out}), 3);
    ticks(SPIN_T);
    chk("done_state", int'(state), 5);
    chk("done_flag", int'(done), 1);
    chk_dig("done", 0, 0);

    pulse_start();
    chk("refill_state", int'(state), 1);
    ticks(FILL_T);
    chk("error_state", int'(state), 6);
    chk("error_flag", int'(err), 1);
    chk("error_act", int'({valve_in, motor, valve_out, spin}), 0);
    chk_dig("error", 0, 0);
    pulse_start();
    chk("ack_state", int'(state), 0);
    chk("ack_err", int'(err), 0);

    pulse_start();
    ticks(FILL_T - 1);
    chk_dig("fill_at_one", 0, 1);
    tick = 1'b1; water_full = 1'b1; cyc(1);
    tick = 1'b0; water_full = 1'b0;
    chk("race_state", int'(state), 2);
    chk_dig("race", 1, 2);

    ticks(WASH_T + DRAIN_T + 3);
    chk("midspin_state", int'(state), 4);
    chk_dig("midspin", 1, 2);
    nCR = 1'b0; #1;
    chk("async_state", int'(state), 0);
    chk_dig("async", 0, 0);
    chk("async_act", int'({valve_in, motor, valve_out, spin, done, err}), 0);
    cyc(2);
    nCR = 1'b1; cyc(2);
    chk("post_rst_state", int'(state), 0);
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
